// File: rtl/tpu_pkg.sv
// Definitions shared by the systolic-array tile path: feeder FSM states, default geometry
// and a width helper.
package tpu_pkg;

    localparam int DATA_W = 8;
    localparam int ROWS   = 4;

    typedef enum logic [2:0] {
        IDLE,
        SKEW,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_e;

    // Bit count needed to index n items; never below 1 so that the counters always exist.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_row_feeder_if.sv
// Bundles the signals between a row feeder, its FIFO, its PE row and the tile controller.
// The slave modport is the feeder. The master modport is whatever drives and observes it.
interface fifo_row_feeder_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] tile_len;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             busy;
    logic             done;
    logic [15:0]      stall_cnt;

    modport master (
        output start, tile_len, fifo_empty, fifo_data,
        input  fifo_rd_en, out_data, out_valid, out_last, busy, done, stall_cnt
    );

    modport slave (
        input  start, tile_len, fifo_empty, fifo_data,
        output fifo_rd_en, out_data, out_valid, out_last, busy, done, stall_cnt
    );
endinterface

// File: rtl/fifo_row_feeder.sv
// Drains one tile from a row FIFO into a PE row. Leading and trailing zero bubbles keep all
// rows in lockstep. Read data appears one cycle after fifo_rd_en. An empty FIFO only inserts
// stall cycles. Optional stall statistics are enabled by FEEDER_STATS_EN.
module fifo_row_feeder
    import tpu_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int ROWS    = tpu_pkg::ROWS,
    parameter int ROW_IDX = 0,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    fifo_row_feeder_if.slave   bus
);

    localparam int CW      = clog2_min1(ROWS);
    localparam int FLUSH_N = ROWS - 1 - ROW_IDX;
    localparam logic [CW-1:0] SKEW_LAST  = CW'((ROW_IDX > 0) ? ROW_IDX - 1 : 0);
    localparam logic [CW-1:0] FLUSH_LAST = CW'((FLUSH_N > 0) ? FLUSH_N - 1 : 0);

    feeder_state_e    state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued_q;
    logic [LEN_W-1:0] received_q;
    logic [CW-1:0]    cnt_q;
    logic             rd_q;

    logic rd_en;
    logic beat;
    logic beat_last;

    // State that follows the skew phase (or IDLE when there is no skew) for a given length.
    function automatic feeder_state_e after_skew(input logic [LEN_W-1:0] len);
        if (len != '0)       return STREAM;
        else if (FLUSH_N > 0) return FLUSH;
        else                 return DONE;
    endfunction

    assign rd_en     = (state_q == STREAM) && !bus.fifo_empty && (issued_q < len_q);
    assign beat      = (state_q == STREAM) && rd_q;
    assign beat_last = beat && ((received_q + LEN_W'(1)) == len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
        end else begin
            rd_q <= rd_en;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        len_q      <= bus.tile_len;
                        issued_q   <= '0;
                        received_q <= '0;
                        cnt_q      <= '0;
                        state_q    <= (ROW_IDX > 0) ? SKEW : after_skew(bus.tile_len);
                    end
                end
                SKEW: begin
                    if (cnt_q == SKEW_LAST) begin
                        cnt_q   <= '0;
                        state_q <= after_skew(len_q);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STREAM: begin
                    if (rd_en) issued_q   <= issued_q + LEN_W'(1);
                    if (rd_q)  received_q <= received_q + LEN_W'(1);
                    if (beat_last) state_q <= (FLUSH_N > 0) ? FLUSH : DONE;
                end
                FLUSH: begin
                    if (cnt_q == FLUSH_LAST) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = (state_q == SKEW) || (state_q == FLUSH) || beat;
    assign bus.out_data   = beat ? bus.fifo_data : '0;
    assign bus.out_last   = beat_last;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);

`ifdef FEEDER_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    // A STREAM cycle without a beat is a stall. This includes the first cycle, which waits on read latency.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && bus.start) begin
            stall_d = '0;
        end else if ((state_q == STREAM) && !rd_q && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_row_feeder.sv
// Bench with all four rows of a 4-row array. Each row has its own modelled FIFO.
// A tile-level model predicts every output on every cycle.
module tb_fifo_row_feeder;

    localparam int NR   = tpu_pkg::ROWS;
    localparam int W    = 8;
    localparam int LW   = 8;
    localparam int MEMN = 2048;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start_s;
    logic [LW-1:0] len_s;
    logic          empty_s [NR];
    logic [W-1:0]  fdat_s  [NR];

    logic          o_rd   [NR];
    logic [W-1:0]  o_dat  [NR];
    logic          o_v    [NR];
    logic          o_l    [NR];
    logic          o_busy [NR];
    logic          o_done [NR];
    logic [15:0]   o_st   [NR];

    genvar g;
    generate
        for (g = 0; g < NR; g++) begin : row
            fifo_row_feeder_if #(.WIDTH(W), .LEN_W(LW)) bus ();
            fifo_row_feeder #(.WIDTH(W), .ROWS(NR), .ROW_IDX(g), .LEN_W(LW)) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );
            assign bus.start      = start_s;
            assign bus.tile_len   = len_s;
            assign bus.fifo_empty = empty_s[g];
            assign bus.fifo_data  = fdat_s[g];
            assign o_rd[g]   = bus.fifo_rd_en;
            assign o_dat[g]  = bus.out_data;
            assign o_v[g]    = bus.out_valid;
            assign o_l[g]    = bus.out_last;
            assign o_busy[g] = bus.busy;
            assign o_done[g] = bus.done;
            assign o_st[g]   = bus.stall_cnt;
        end
    endgenerate

    // FIFO contents per row: entries rp..wp-1 are still queued.
    logic [W-1:0] mem [NR][MEMN];
    int  wp [NR];
    int  rp [NR];
    bit  pend_rd [NR];

    // Tile model per row.
    bit  act [NR];
    int  t [NR];
    int  mlen [NR];
    int  base [NR];
    int  reads [NR];
    int  recv [NR];
    int  e_end [NR];
    bit  prev_rd [NR];
    int  stall_m [NR];
    int  rdcnt [NR];
    int  done_at [NR];
    logic [W-1:0] tr0 [32];

    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  tile_cyc = 0;
    int  force_mode = 0;
    int  gap_lo = 0;
    int  gap_hi = 0;
    bit  refill_on = 0;
    logic          start_nx;
    logic          rst_nx;
    logic [LW-1:0] len_nx;

    task automatic chk(input string nm, input int r, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s row%0d got=%0h expected=%0h cycle=%0d", nm, r, got, exp, cyc);
        end
    endtask

    task automatic push(input int r, input logic [W-1:0] d);
        if (wp[r] < MEMN) begin
            mem[r][wp[r]] = d;
            wp[r]++;
        end
    endtask

    task automatic flush_fifos();
        for (int r = 0; r < NR; r++) rp[r] = wp[r];
    endtask

    function automatic bit any_act();
        bit a;
        a = 0;
        for (int r = 0; r < NR; r++) a |= act[r];
        return a;
    endfunction

    // Tile timeline for row r: R skew beats, then len FIFO entries in order, each one cycle after
    // its read. Then F flush beats, then a done cycle. Here R = r and F = NR-1-r.
    task automatic check_row(input int r);
        int R, F, k;
        logic e_rd, e_v, e_l, e_busy, e_done;
        logic [W-1:0] e_d;
        logic [15:0]  e_st;
        R = r;
        F = NR - 1 - r;
        e_rd = 0; e_v = 0; e_l = 0; e_busy = 0; e_done = 0; e_d = '0; k = 0;
`ifdef FEEDER_STATS_EN
        e_st = 16'(stall_m[r]);
`else
        e_st = 16'd0;
`endif
        if (act[r] && t[r] > 0) begin
            e_busy = 1;
            if (t[r] <= R) begin
                e_v = 1;
            end else if (e_end[r] < 0) begin
                e_rd = !empty_s[r] && (reads[r] < mlen[r]);
                e_v  = prev_rd[r];
                if (prev_rd[r]) begin
                    e_d = mem[r][base[r] + recv[r]];
                    e_l = ((recv[r] + 1) == mlen[r]);
                end
            end else begin
                k = t[r] - e_end[r];
                if (k <= F) e_v = 1;
                else        e_done = 1;
            end
        end
        chk("rd_en",     r, 32'(o_rd[r]),   32'(e_rd));
        chk("valid",     r, 32'(o_v[r]),    32'(e_v));
        chk("data",      r, 32'(o_dat[r]),  32'(e_d));
        chk("last",      r, 32'(o_l[r]),    32'(e_l));
        chk("busy",      r, 32'(o_busy[r]), 32'(e_busy));
        chk("done",      r, 32'(o_done[r]), 32'(e_done));
        chk("stall_cnt", r, 32'(o_st[r]),   32'(e_st));
        if (act[r]) begin
            if (r == 0 && t[r] < 32) tr0[t[r]] = o_dat[r];
            if (o_rd[r] === 1'b1) rdcnt[r]++;
            if (o_done[r] === 1'b1) done_at[r] = t[r];
            if (t[r] == 0) begin
                stall_m[r] = 0;
            end else if (t[r] > R && e_end[r] < 0) begin
                if (!e_v && stall_m[r] < 65535) stall_m[r]++;
                if (e_v)  recv[r]++;
                if (e_rd) reads[r]++;
                prev_rd[r] = e_rd;
                if (e_l) e_end[r] = t[r];
            end
            if (e_done) act[r] = 0;
            t[r]++;
        end
    endtask

    // One clock: inputs change 1 time unit after the rising edge, and outputs are checked on the falling edge.
    task automatic cycle();
        bit force_e;
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_nx;
        if (rst_nx) begin
            for (int r = 0; r < NR; r++) begin
                act[r] = 0;
                stall_m[r] = 0;
            end
        end
        for (int r = 0; r < NR; r++) begin
            if (pend_rd[r] && rp[r] < wp[r]) begin
                fdat_s[r] = mem[r][rp[r]];
                rp[r]++;
            end
            if (refill_on && $urandom_range(0, 3) == 0) push(r, W'($urandom));
        end
        start_s  = start_nx;
        len_s    = len_nx;
        start_nx = 0;
        if (start_s && !rst_nx) begin
            tile_cyc = cyc;
            for (int r = 0; r < NR; r++) begin
                if (!act[r]) begin
                    act[r] = 1; t[r] = 0; mlen[r] = int'(len_s); base[r] = rp[r];
                    reads[r] = 0; recv[r] = 0; prev_rd[r] = 0; rdcnt[r] = 0; done_at[r] = -1;
                    e_end[r] = (len_s == '0) ? r : -1;
                end
            end
        end
        force_e = (force_mode == 1 && (cyc - tile_cyc) >= gap_lo && (cyc - tile_cyc) <= gap_hi) ||
                  (force_mode == 2 && $urandom_range(0, 3) == 0);
        for (int r = 0; r < NR; r++) empty_s[r] = (rp[r] >= wp[r]) || force_e;
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            check_row(r);
            pend_rd[r] = (o_rd[r] === 1'b1);
        end
    endtask

    task automatic run_tile(input int len, input int budget);
        int n;
        len_nx = LW'(len);
        start_nx = 1;
        cycle();
        n = 0;
        while (any_act() && n < budget) begin
            cycle();
            n++;
        end
        if (any_act()) begin
            n_chk++;
            n_fail++;
            $display("FAIL tile_timeout got=busy expected=idle within %0d cycles", budget);
            rst_nx = 1;
            cycle();
            rst_nx = 0;
            cycle();
        end
        cycle();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; rst_nx = 1; start_s = 0; len_s = '0; start_nx = 0; len_nx = '0;
        for (int r = 0; r < NR; r++) begin
            empty_s[r] = 1; fdat_s[r] = '0; wp[r] = 0; rp[r] = 0; pend_rd[r] = 0;
            act[r] = 0; t[r] = 0; stall_m[r] = 0; rdcnt[r] = 0; done_at[r] = -1;
            mlen[r] = 0; base[r] = 0; reads[r] = 0; recv[r] = 0; e_end[r] = -1; prev_rd[r] = 0;
        end
        for (int i = 0; i < 32; i++) tr0[i] = '0;

        repeat (3) cycle();
        rst_nx = 0;
        repeat (2) cycle();

        // Basic tile: every row finishes on the same cycle.
        for (int r = 0; r < NR; r++) begin push(r, 8'h11); push(r, 8'h22); push(r, 8'h33); end
        run_tile(3, 100);
        for (int r = 0; r < NR; r++) begin
            chk("t1_done_cycle", r, 32'(done_at[r]), 32'd8);
            chk("t1_reads",      r, 32'(rdcnt[r]),   32'd3);
        end
        chk("t1_beat_t2", 0, 32'(tr0[2]), 32'h11);
        chk("t1_beat_t3", 0, 32'(tr0[3]), 32'h22);
        chk("t1_beat_t4", 0, 32'(tr0[4]), 32'h33);

        // The FIFO reads empty in cycles 2-4 of the tile.
        flush_fifos();
        for (int r = 0; r < NR; r++) begin push(r, 8'h11); push(r, 8'h22); push(r, 8'h33); end
        force_mode = 1; gap_lo = 2; gap_hi = 4;
        run_tile(3, 100);
        force_mode = 0;
        chk("t2_beat_t2", 0, 32'(tr0[2]), 32'h11);
        chk("t2_beat_t6", 0, 32'(tr0[6]), 32'h22);
        chk("t2_beat_t7", 0, 32'(tr0[7]), 32'h33);
        chk("t2_done_cycle", 0, 32'(done_at[0]), 32'd11);

        // An empty tile produces bubbles only. The FIFO is left untouched.
        flush_fifos();
        for (int r = 0; r < NR; r++) begin push(r, 8'h5A); push(r, 8'hA5); end
        run_tile(0, 100);
        for (int r = 0; r < NR; r++) begin
            chk("t3_reads",      r, 32'(rdcnt[r]),       32'd0);
            chk("t3_done_cycle", r, 32'(done_at[r]),     32'd4);
            chk("t3_fifo_left",  r, 32'(wp[r] - rp[r]),  32'd2);
        end

        // Surplus entries stay in the FIFO for the next tile.
        flush_fifos();
        for (int r = 0; r < NR; r++) for (int i = 1; i <= 5; i++) push(r, 8'(8'hC0 + i));
        run_tile(2, 100);
        chk("t4_reads",     0, 32'(rdcnt[0]),      32'd2);
        chk("t4_fifo_left", 0, 32'(wp[0] - rp[0]), 32'd3);
        chk("t4_not_empty", 0, 32'(empty_s[0]),    32'd0);
        run_tile(1, 100);
        chk("t4_next_beat", 0, 32'(tr0[2]),        32'hC3);
        chk("t4_fifo_left2", 0, 32'(wp[0] - rp[0]), 32'd2);

        // Reset during STREAM, one read into a four-element tile.
        flush_fifos();
        for (int r = 0; r < NR; r++) for (int i = 1; i <= 4; i++) push(r, 8'(8'hA0 + i));
        len_nx = LW'(4); start_nx = 1;
        cycle();
        cycle();
        chk("t5_reads_before_rst", 0, 32'(rdcnt[0]), 32'd1);
        rst_nx = 1;
        cycle();
        rst_nx = 0;
        cycle();
        run_tile(1, 100);
        chk("t5_beat_after_rst", 0, 32'(tr0[2]), 32'hA2);
        chk("t5_done_cycle",     0, 32'(done_at[0]), 32'd6);

        // Random tiles, FIFO gaps, refills and stray start pulses.
        force_mode = 2;
        refill_on = 1;
        for (int i = 0; i < 40; i++) begin
            int n;
            for (int r = 0; r < NR; r++) repeat ($urandom_range(0, 6)) push(r, W'($urandom));
            len_nx = LW'($urandom_range(0, 12));
            start_nx = 1;
            cycle();
            n = 0;
            while (any_act() && n < 400) begin
                if ($urandom_range(0, 19) == 0) begin
                    start_nx = 1;
                    len_nx = LW'($urandom_range(0, 12));
                end
                cycle();
                n++;
            end
            if (any_act()) begin
                n_chk++;
                n_fail++;
                $display("FAIL rand_timeout got=busy expected=idle tile=%0d", i);
                rst_nx = 1;
                cycle();
                rst_nx = 0;
            end
            repeat ($urandom_range(1, 3)) cycle();
        end
        force_mode = 0;
        refill_on = 0;
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
